// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL loop filter.
// Lock FSM states, default centre word, saturate/clamp helpers.
package pll_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRING,
        LOCKED
    } lock_state_t;

    localparam int CENTER_DEFAULT = 128;

    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [63:0] clamp_unsigned(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pll_loop_filter_if.sv
// Phase-error in / control-word out bundle of the loop filter.
// master = phase-detector side, slave = loop filter.
interface pll_loop_filter_if #(
    parameter int BITS     = 8,
    parameter int ERR_BITS = 12
);
    logic signed [ERR_BITS-1:0] err;
    logic                       err_valid;
    logic        [BITS-1:0]     ctrl;
    logic                       ctrl_valid;
    logic                       locked;

    modport master (
        output err, err_valid,
        input  ctrl, ctrl_valid, locked
    );

    modport slave (
        input  err, err_valid,
        output ctrl, ctrl_valid, locked
    );
endinterface

// File: rtl/pll_lock_detect.sv
// Lock detector: counts consecutive in/out-of-tolerance samples.
// locked is registered one edge behind the FSM state.
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int ERR_BITS     = 12,
    parameter int LOCK_TOL     = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [ERR_BITS-1:0] err,
    input  logic                       err_valid,
    output logic                       locked
);
    localparam int MAXC = (LOCK_COUNT > UNLOCK_COUNT)
                        ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [ERR_BITS-1:0] ERR_MIN =
        {1'b1, {(ERR_BITS-1){1'b0}}};

    lock_state_t           state;
    lock_state_t           state_n;
    logic        [CW-1:0]  cnt;
    logic        [CW-1:0]  cnt_n;
    logic        [CW-1:0]  cnt_inc;
    logic [ERR_BITS-1:0]   mag;
    logic                  in_tol;

    // magnitude check; the most negative code has no positive twin
    always_comb begin
        mag = err[ERR_BITS-1] ? $unsigned(-err) : $unsigned(err);
        in_tol = ($unsigned(err) != ERR_MIN) &&
                 (mag <= ERR_BITS'(LOCK_TOL));
        cnt_inc = cnt + 1'b1;
    end

    // next-state logic, only advanced by accepted samples
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (err_valid) begin
            unique case (state)
                UNLOCKED: begin
                    if (in_tol) begin
                        if (LOCK_COUNT == 1) begin
                            state_n = LOCKED;
                            cnt_n   = '0;
                        end else begin
                            state_n = ACQUIRING;
                            cnt_n   = CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                ACQUIRING: begin
                    if (!in_tol) begin
                        state_n = UNLOCKED;
                        cnt_n   = '0;
                    end else if (cnt_inc == CW'(LOCK_COUNT)) begin
                        state_n = LOCKED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                LOCKED: begin
                    if (in_tol) begin
                        cnt_n = '0;
                    end else if (cnt_inc == CW'(UNLOCK_COUNT)) begin
                        state_n = UNLOCKED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = UNLOCKED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // state, counter and registered lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= UNLOCKED;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            locked <= (state == LOCKED);
        end
    end

endmodule

// File: rtl/pll_loop_filter.sv
// PI loop filter: phase error in, VCO control word out.
// Sample register, integrator stage, then sum/clamp stage.
module pll_loop_filter
    import pll_pkg::*;
#(
    parameter int BITS         = 8,
    parameter int ERR_BITS     = 12,
    parameter int ACC_BITS     = 20,
    parameter int KP_SHIFT     = 2,
    parameter int KI_SHIFT     = 6,
    parameter int CENTER       = CENTER_DEFAULT,
    parameter int LOCK_TOL     = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input logic               clk,
    input logic               rst,
    pll_loop_filter_if.slave  bus
);
    localparam logic signed [63:0] CTRL_MAX =
        (64'sd1 <<< BITS) - 64'sd1;

    logic signed [ERR_BITS-1:0]   err_q;
    logic                         v0;
    logic signed [ACC_BITS-1:0]   integ;
    logic signed [ERR_BITS-1:0]   prop;
    logic                         v1;
    logic        [BITS-1:0]       ctrl_q;
    logic                         cv_q;

    logic signed [63:0]           integ_sum;
    logic signed [ACC_BITS-1:0]   integ_nxt;
    logic signed [ACC_BITS+1:0]   sum;
    logic        [BITS-1:0]       ctrl_nxt;

    // saturating integrator update and output sum/clamp
    always_comb begin
        integ_sum = 64'(integ) + 64'(err_q);
        integ_nxt = ACC_BITS'(sat_signed(integ_sum, ACC_BITS));
        sum = (ACC_BITS+2)'(CENTER)
            + (ACC_BITS+2)'(prop)
            + (ACC_BITS+2)'(integ >>> KI_SHIFT);
        ctrl_nxt = BITS'(clamp_unsigned(64'(sum), 64'sd1, CTRL_MAX));
    end

    // capture accepted phase-error samples
    always_ff @(posedge clk) begin
        if (rst) begin
            v0    <= 1'b0;
            err_q <= '0;
        end else begin
            v0 <= bus.err_valid;
            if (bus.err_valid) err_q <= bus.err;
        end
    end

    // stage 1: integrator and proportional term
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            integ <= '0;
            prop  <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                integ <= integ_nxt;
                prop  <= err_q >>> KP_SHIFT;
            end
        end
    end

    // stage 2: control word, held between updates
    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q   <= 1'b0;
            ctrl_q <= BITS'(CENTER);
        end else begin
            cv_q <= v1;
            if (v1) ctrl_q <= ctrl_nxt;
        end
    end

    assign bus.ctrl       = ctrl_q;
    assign bus.ctrl_valid = cv_q;

    pll_lock_detect #(
        .ERR_BITS     (ERR_BITS),
        .LOCK_TOL     (LOCK_TOL),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock (
        .clk       (clk),
        .rst       (rst),
        .err       (bus.err),
        .err_valid (bus.err_valid),
        .locked    (bus.locked)
    );

endmodule

// File: tb/tb_pll_loop_filter.sv
// Bench for pll_loop_filter: scoreboard of expected ctrl words
// from a reference PI model, plus direct lock/latency checks.
module tb_pll_loop_filter;
    import pll_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_loop_filter_if #(.BITS(8), .ERR_BITS(12)) bus();

    pll_loop_filter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int obs_q[$];
    int m_integ = 0;
    int run = 0;
    int max_run = 0;

    task automatic send(input int e);
        int p;
        int s;
        bus.err = 12'(e);
        bus.err_valid = 1'b1;
        m_integ = m_integ + e;
        if (m_integ > 524287) m_integ = 524287;
        else if (m_integ < -524288) m_integ = -524288;
        p = e >>> 2;
        s = 128 + p + (m_integ >>> 6);
        if (s < 1) s = 1;
        else if (s > 255) s = 255;
        exp_q.push_back(s);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.err_valid = 1'b0;
        bus.err = 12'sh155;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.err_valid = 1'b0;
        bus.err = '0;
        exp_q.delete();
        obs_q.delete();
        m_integ = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.err_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d outputs pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            if (bus.ctrl_valid === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                obs_q.push_back(int'(bus.ctrl));
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: ctrl=%0d, required no output",
                             bus.ctrl);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.ctrl) !== e) begin
                        fails++;
                        $display("FAIL sb_ctrl: got %0d, required %0d",
                                 bus.ctrl, e);
                    end
                end
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if (bus.ctrl !== 8'd128) begin
            fails++;
            $display("FAIL reset_ctrl: got %0d, required 128", bus.ctrl);
        end
        tests++;
        if (bus.ctrl_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, required 0", bus.ctrl_valid);
        end
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_locked: got %b, required 0", bus.locked);
        end
    endtask

    task automatic test_latency();
        logic [2:0] cv;
        do_reset();
        send(0);
        bus.err_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cv[i] = bus.ctrl_valid;
        end
        tests++;
        if (cv !== 3'b100) begin
            fails++;
            $display("FAIL latency_valid: got %b, required 100", cv);
        end
        tests++;
        if (bus.ctrl !== 8'd128) begin
            fails++;
            $display("FAIL latency_ctrl: got %0d, required 128", bus.ctrl);
        end
        @(negedge clk);
        tests++;
        if (bus.ctrl_valid !== 1'b0 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL latency_pulse: valid=%b locked=%b, required 0 0",
                     bus.ctrl_valid, bus.locked);
        end
        drain("latency");
    endtask

    task automatic test_single();
        do_reset();
        send(40);
        send(0);
        drain("single");
        tests++;
        if (obs_q.size() != 2) begin
            fails++;
            $display("FAIL single_count: got %0d, required 2", obs_q.size());
        end else if (obs_q[0] != 138 || obs_q[1] != 128) begin
            fails++;
            $display("FAIL single_vals: got %0d %0d, required 138 128",
                     obs_q[0], obs_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        max_run = 0;
        repeat (64) send(64);
        drain("b2b");
        tests++;
        if (max_run != 64) begin
            fails++;
            $display("FAIL b2b_run: got %0d, required 64", max_run);
        end
        tests++;
        if (obs_q.size() != 64 || obs_q[$] != 208) begin
            fails++;
            $display("FAIL b2b_final: n=%0d last=%0d, required 64 208",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[$] : -1);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        send(2047);
        drain("clamp_hi");
        tests++;
        if (obs_q.size() != 1 || obs_q[0] != 255) begin
            fails++;
            $display("FAIL clamp_hi: got %0d, required 255",
                     (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        do_reset();
        send(-2048);
        drain("clamp_lo");
        tests++;
        if (obs_q.size() != 1 || obs_q[0] != 1) begin
            fails++;
            $display("FAIL clamp_lo: got %0d, required 1",
                     (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        do_reset();
        repeat (260) send(2047);
        repeat (240) send(-2048);
        drain("sat");
        tests++;
        if (obs_q.size() != 500 || obs_q[$] != 127) begin
            fails++;
            $display("FAIL integ_sat: n=%0d last=%0d, required 500 127",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[$] : -1);
        end
    endtask

    task automatic test_lock();
        int tv[5] = '{3, -4, 4, 0, -1};
        logic [1:0] lk;
        do_reset();
        for (int i = 0; i < 15; i++) send(tv[i % 5]);
        idle(3);
        @(negedge clk);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL lock_15: got %b, required 0", bus.locked);
        end
        @(posedge clk); #1;
        send(3);
        bus.err_valid = 1'b0;
        @(negedge clk);
        lk[0] = bus.locked;
        @(negedge clk);
        lk[1] = bus.locked;
        tests++;
        if (lk !== 2'b10) begin
            fails++;
            $display("FAIL lock_16: got %b, required 10", lk);
        end
        repeat (3) send(10);
        send(0);
        idle(2);
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_hold: got %b, required 1", bus.locked);
        end
        repeat (3) send(10);
        idle(2);
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_3bad: got %b, required 1", bus.locked);
        end
        send(-2048);
        idle(2);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL lock_min: got %b, required 0", bus.locked);
        end
        repeat (16) send(0);
        idle(2);
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL relock: got %b, required 1", bus.locked);
        end
        repeat (4) send(10);
        idle(2);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL unlock_4: got %b, required 0", bus.locked);
        end
        drain("lock");
    endtask

    task automatic test_acq_reset();
        do_reset();
        repeat (10) send(3);
        send(5);
        repeat (15) send(3);
        idle(2);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL acq_restart: got %b, required 0", bus.locked);
        end
        send(3);
        idle(2);
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL acq_lock: got %b, required 1", bus.locked);
        end
        drain("acq");
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        send(100);
        rst = 1'b1;
        bus.err_valid = 1'b0;
        exp_q.delete();
        obs_q.delete();
        m_integ = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ctrl_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0 || bus.ctrl !== 8'd128) begin
            fails++;
            $display("FAIL rst_flush: valids=%0d ctrl=%0d, required 0 128",
                     seen, bus.ctrl);
        end
        @(posedge clk); #1;
        send(0);
        drain("rst_mid");
        tests++;
        if (obs_q.size() != 1 || obs_q[0] != 128) begin
            fails++;
            $display("FAIL rst_integ: got %0d, required 128",
                     (obs_q.size() > 0) ? obs_q[0] : -1);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send(40);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.ctrl !== 8'd138 || bus.ctrl_valid !== 1'b0) begin
                fails++;
                $display("FAIL gap_hold: ctrl=%0d valid=%b, required 138 0",
                         bus.ctrl, bus.ctrl_valid);
            end
        end
        @(posedge clk); #1;
        send(40);
        drain("gaps");
        tests++;
        if (obs_q.size() != 2 || obs_q[1] != 139) begin
            fails++;
            $display("FAIL gap_integ: got %0d, required 139",
                     (obs_q.size() > 1) ? obs_q[1] : -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.err = '0;
        bus.err_valid = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_latency();
        test_single();
        test_back_to_back();
        test_clamp();
        test_lock();
        test_acq_reset();
        test_reset_mid();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
